// File: rtl/correlator_sequencer.sv
// Frame controller for the correlator counter bank: clear, integrate, settle, then stream the
// lag words out over valid/ready and either stop or re-arm.
module correlator_sequencer #(
    parameter int unsigned MAX_DELAY  = 501,
    parameter int unsigned RESOLUTION = 32,
    parameter int unsigned INT_WIDTH  = 32,
    parameter int unsigned IDX_WIDTH  = $clog2(MAX_DELAY)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            continuous,
    input  logic                            abort,
    input  logic [INT_WIDTH-1:0]            int_cycles,
    input  logic [RESOLUTION*MAX_DELAY-1:0] corr_in,
    output logic                            count_clr,
    output logic                            count_en,
    output logic [RESOLUTION-1:0]           out_data,
    output logic [IDX_WIDTH-1:0]            out_index,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic [15:0]                     frames_done
);

    typedef enum logic [2:0] {StIdle, StClear, StIntegrate, StSettle, StReadout} state_e;

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(MAX_DELAY - 1);

    state_e                 state_q, state_d;
    logic [INT_WIDTH-1:0]   rem_q, rem_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d, idx_inc;
    logic [RESOLUTION-1:0]  data_q, data_d;
    logic [15:0]            frames_q, frames_d;

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        data_d   = data_q;
        frames_d = frames_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                rem_d   = (int_cycles == '0) ? INT_WIDTH'(1) : int_cycles;
                state_d = StIntegrate;
            end
            StIntegrate: begin
                rem_d = rem_q - 1'b1;
                if (rem_q <= INT_WIDTH'(1)) state_d = StSettle;
            end
            StSettle: begin
                idx_d   = '0;
                data_d  = corr_in[RESOLUTION-1:0];
                state_d = StReadout;
            end
            StReadout: begin
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        // An aborted frame never counts as completed.
                        if (!abort) frames_d = frames_q + 16'd1;
                        state_d = continuous ? StClear : StIdle;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = corr_in[RESOLUTION*32'(idx_inc) +: RESOLUTION];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            frames_q <= frames_d;
        end
    end

    // Strobes decode the state register only, so no input reaches an output combinationally.
    assign count_clr   = (state_q == StClear);
    assign count_en    = (state_q == StIntegrate);
    assign out_valid   = (state_q == StReadout);
    assign out_last    = (state_q == StReadout) && (idx_q == LastIdx);
    assign busy        = (state_q != StIdle);
    assign out_data    = data_q;
    assign out_index   = idx_q;
    assign frames_done = frames_q;

endmodule

// File: tb/tb_correlator_sequencer.sv
// Directed bench for correlator_sequencer with MAX_DELAY=4, RESOLUTION=8.
module tb_correlator_sequencer;

    localparam int MD = 4;
    localparam int RS = 8;
    localparam int IW = 8;

    logic          clk, reset, start, continuous, abort, out_ready;
    logic [IW-1:0] int_cycles;
    logic [RS*MD-1:0] corr_in;
    logic          count_clr, count_en, out_last, out_valid, busy;
    logic [RS-1:0] out_data;
    logic [1:0]    out_index;
    logic [15:0]   frames_done;

    int errors = 0;
    int checks = 0;

    // Filled by observe()
    int clr_n, en_n, first_valid, last_n;
    int clr_cyc[$];
    logic [7:0] wdata[$];
    logic [1:0] widx[$];
    logic       wlast[$];

    correlator_sequencer #(
        .MAX_DELAY(MD), .RESOLUTION(RS), .INT_WIDTH(IW), .IDX_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
        .int_cycles(int_cycles), .corr_in(corr_in), .count_clr(count_clr),
        .count_en(count_en), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frames_done(frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Watch ncyc cycles starting with the current one (cycle 1); out_ready follows pat while
    // out_valid is high, then defaults to 1.
    task automatic observe(input int ncyc, input logic [15:0] pat, input int plen);
        int k;
        logic stalled;
        logic [7:0] pd;
        logic [1:0] pi;
        k = 0; stalled = 1'b0; pd = '0; pi = '0;
        clr_n = 0; en_n = 0; first_valid = -1; last_n = 0;
        clr_cyc.delete(); wdata.delete(); widx.delete(); wlast.delete();
        for (int c = 1; c <= ncyc; c++) begin
            if (count_clr) begin clr_n++; clr_cyc.push_back(c); end
            if (count_en) en_n++;
            if (out_last) last_n++;
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (stalled) begin
                    chk("stall_data", out_data, pd);
                    chk("stall_index", out_index, pi);
                end
                out_ready = (k < plen) ? pat[k] : 1'b1;
                k++;
                if (out_ready) begin
                    wdata.push_back(out_data);
                    widx.push_back(out_index);
                    wlast.push_back(out_last);
                end
                stalled = !out_ready;
                pd = out_data;
                pi = out_index;
            end else begin
                stalled = 1'b0;
            end
            tick();
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nwords"}, wdata.size(), MD);
        chk({tag, "_nlast"}, last_n, 1);
        for (int i = 0; i < MD; i++) begin
            chk({tag, "_data"}, (i < wdata.size()) ? wdata[i] : 8'hxx, corr_in[RS*i +: RS]);
            chk({tag, "_index"}, (i < widx.size()) ? widx[i] : 2'bxx, i);
            chk({tag, "_last"}, (i < wlast.size()) ? wlast[i] : 1'bx, (i == MD - 1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; out_ready = 1'b1;
        int_cycles = '0; corr_in = 32'h44332211;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_clr", count_clr, 0);
        chk("rst_en", count_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_done, 0);

        // Single frame, N=5: clr c1, en c2..6, settle c7, readout c8..11, idle c12
        int_cycles = 8'd5;
        start_frame();
        chk("single_busy", busy, 1);
        observe(12, 16'h0000, 0);
        chk("single_clr_n", clr_n, 1);
        chk("single_en_n", en_n, 5);
        chk("single_first_valid", first_valid, 8);
        check_stream("single");
        chk("single_busy_end", busy, 0);
        chk("single_frames", frames_done, 1);

        // Backpressure, N=2: ready pattern 1,0,0,1,0,1,1 across readout c5..11
        int_cycles = 8'd2;
        corr_in = 32'hD4C3B2A1;
        start_frame();
        observe(12, 16'b0000_0000_0110_1001, 7);
        check_stream("bp");
        chk("bp_busy_end", busy, 0);
        chk("bp_frames", frames_done, 2);

        // Continuous, N=3: clr at c1, c10, c19
        int_cycles = 8'd3;
        continuous = 1'b1;
        corr_in = 32'h44332211;
        start_frame();
        observe(20, 16'h0000, 0);
        chk("cont_clr_n", clr_n, 3);
        chk("cont_gap1", (clr_cyc.size() > 1) ? clr_cyc[1] - clr_cyc[0] : -1, 9);
        chk("cont_gap2", (clr_cyc.size() > 2) ? clr_cyc[2] - clr_cyc[1] : -1, 9);
        chk("cont_frames_mid", frames_done, 4);
        continuous = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("cont_busy_end", busy, 0);
        chk("cont_frames_end", frames_done, 5);

        // int_cycles = 0 behaves as 1
        int_cycles = 8'd0;
        start_frame();
        observe(8, 16'h0000, 0);
        chk("zero_en_n", en_n, 1);
        chk("zero_first_valid", first_valid, 4);
        check_stream("zero");
        chk("zero_frames", frames_done, 6);

        // Abort at index 2 while stalled
        int_cycles = 8'd1;
        start_frame();
        observe(6, 16'b011, 3);
        chk("abort_pre_valid", out_valid, 1);
        chk("abort_pre_index", out_index, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_en", count_en, 0);
        chk("abort_frames", frames_done, 6);
        tick();
        chk("abort_stay_idle", busy, 0);
        start_frame();
        observe(8, 16'h0000, 0);
        check_stream("post_abort");
        chk("post_abort_frames", frames_done, 7);

        // Asynchronous reset mid-integration
        int_cycles = 8'd5;
        start_frame();
        tick(); tick();
        chk("ar_en_before", count_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_en", count_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_clr", count_clr, 0);
        chk("ar_data", out_data, 0);
        chk("ar_index", out_index, 0);
        chk("ar_frames", frames_done, 0);
        tick();
        reset = 1'b0;
        tick();
        int_cycles = 8'd2;
        start_frame();
        observe(9, 16'h0000, 0);
        chk("ar_post_en_n", en_n, 2);
        check_stream("ar_post");
        chk("ar_post_frames", frames_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
